significand_divider: RTL and testbench

- Sequential radix-2 restoring divider for half-precision significands. It is the inverse-direction companion of booth_multiplier in the FP datapath.
- Takes two 10-bit fractions plus zero flags and produces a QW-bit quotient of the hidden-bit significands, one bit per clock.
- Feeds the FP divide normalize/round stage.

---
 rtl/significand_divider.sv | 128 ++++++++++++
 tb/tb_significand_divider.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/significand_divider.sv
// Sequential radix-2 restoring divider for half-precision significands: q = floor(ma*2^(QW-1)/mb), one bit per clock.
// Optional post-normalisation (one extra quotient bit plus exp_dec) is enabled by defining SIGDIV_NORM_EN.
module significand_divider #(
  parameter int FW = 10,
  parameter int QW = 13
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  input  logic          azero,
  input  logic          bzero,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          dz,
  output logic          exp_dec,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(QW);

  // Handshake: start is a request taken only while IDLE (ready == IDLE, busy/done low);
  // a request seen in RUN or DONE is dropped. done is a one-cycle valid with no back-pressure,
  // and the result stays on q/sticky/dz/exp_dec until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [FW:0]     mb;
  logic [FW+1:0]   r;
  logic [CW-1:0]   cnt;

  logic            ge;
  logic [FW+1:0]   rem;
  logic [FW+1:0]   r_shift;
  logic [QW-1:0]   q_step;
  logic [QW-1:0]   q_fin;
  logic [FW+1:0]   r_fin;
  logic            sticky_fin;
  logic            xd_fin;

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (azero || bzero) ? DONE : RUN;
      RUN:     if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // One restoring step; r < 2*mb keeps the difference below 2^(FW+1), so the shift never overflows.
  always_comb begin
    ge          = (r >= {1'b0, mb});
    rem         = ge ? (r - {1'b0, mb}) : r;
    r_shift     = {rem[FW:0], 1'b0};
    q_step      = q;
    q_step[cnt] = ge;
    q_fin       = q_step;
    r_fin       = r_shift;
    sticky_fin  = (r_shift != '0);
    xd_fin      = 1'b0;
`ifdef SIGDIV_NORM_EN
    // Quotient below 1.0: develop one more bit so the MSB is set, and ask for an exponent decrement.
    if (!q_step[QW-1]) begin
      q_fin      = {q_step[QW-2:0], (r_shift >= {1'b0, mb})};
      r_fin      = (r_shift >= {1'b0, mb}) ? (r_shift - {1'b0, mb}) : r_shift;
      sticky_fin = (r_fin != '0);
      xd_fin     = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mb      <= '0;
      r       <= '0;
      cnt     <= '0;
      q       <= '0;
      sticky  <= 1'b0;
      dz      <= 1'b0;
      exp_dec <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mb      <= {~bzero, b};
            r       <= {1'b0, ~azero, a};
            cnt     <= CW'(QW - 1);
            q       <= '0;
            sticky  <= 1'b0;
            dz      <= bzero;
            exp_dec <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            q       <= q_fin;
            r       <= r_fin;
            sticky  <= sticky_fin;
            exp_dec <= xd_fin;
          end else begin
            q <= q_step;
            r <= r_shift;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_significand_divider.sv
// Randomised bench for significand_divider against a plain-arithmetic reference model.
// Build with SIGDIV_NORM_EN defined to check the normalising variant.
module tb_significand_divider;

  localparam int FW = 10;
  localparam int QW = 13;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [FW-1:0] a;
  logic [FW-1:0] b;
  logic          azero;
  logic          bzero;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;
  logic          sticky;
  logic          dz;
  logic          exp_dec;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Packed expected result: {exp_dec, dz, sticky, q}
  logic [QW+2:0] exp_q[$];

  significand_divider #(.FW(FW), .QW(QW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .a         (a),
    .b         (b),
    .azero     (azero),
    .bzero     (bzero),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .sticky    (sticky),
    .dz        (dz),
    .exp_dec   (exp_dec),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: long division done with integer arithmetic on the hidden-bit significands.
  task automatic model(input logic [FW-1:0] ai, input logic [FW-1:0] bi, input logic az,
                       input logic bz, output logic [QW+2:0] res, output int lat);
    longint ma, mb, num, qq, rr;
    logic xd;
    ma = az ? 0 : (longint'(1) << FW) + longint'(ai);
    mb = bz ? 0 : (longint'(1) << FW) + longint'(bi);
    xd = 1'b0;
    if (bz) begin
      res = {1'b0, 1'b1, 1'b0, {QW{1'b0}}};
      lat = 1;
    end else if (az) begin
      res = '0;
      lat = 1;
    end else begin
      num = ma << (QW - 1);
      qq  = num / mb;
      rr  = num % mb;
`ifdef SIGDIV_NORM_EN
      if (qq < (longint'(1) << (QW - 1))) begin
        num = ma << QW;
        qq  = num / mb;
        rr  = num % mb;
        xd  = 1'b1;
      end
`endif
      res = {xd, 1'b0, (rr != 0), qq[QW-1:0]};
      lat = QW + 1;
    end
  endtask

  // Driver + monitor for one operation; inj = cycle at which a competing start is driven (0 = none).
  task automatic run_op(input logic [FW-1:0] ai, input logic [FW-1:0] bi, input logic az,
                        input logic bz, input int inj);
    logic [QW+2:0] e;
    int lat;
    int ndone;
    model(ai, bi, az, bz, e, lat);
    exp_q.push_back(e);
    a = ai; b = bi; azero = az; bzero = bz; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= QW + 3; cyc++) begin
      check("busy", 32'(busy), 32'(lat > 1 && cyc < lat));
      check("done", 32'(done), 32'(cyc == lat));
      if (done) begin
        ndone++;
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("q", 32'(q), 32'(e[QW-1:0]));
          check("sticky", 32'(sticky), 32'(e[QW]));
          check("dz", 32'(dz), 32'(e[QW+1]));
          check("exp_dec", 32'(exp_dec), 32'(e[QW+2]));
        end
      end
      if (cyc == inj) begin
        a = FW'($urandom); b = FW'($urandom); azero = 1'b0; bzero = 1'b0; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check("done_count", 32'(ndone), 32'd1);
    check("q_held", 32'(q), 32'(e[QW-1:0]));
  endtask

  task automatic abort_op(input logic [FW-1:0] ai, input logic [FW-1:0] bi, input int at);
    a = ai; b = bi; azero = 1'b0; bzero = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < at; cyc++) begin
      check("abort_busy", 32'(busy), 32'd1);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_busy_clr", 32'(busy), 32'd0);
    check("abort_q_clr", 32'(q), 32'd0);
    for (int cyc = 0; cyc < QW + 2; cyc++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick();
    end
  endtask

  initial begin
    int inj;
    logic az, bz;
    RST = 1'b1; start = 1'b0; a = '0; b = '0; azero = 1'b0; bzero = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_flags", 32'({sticky, dz, exp_dec}), 32'd0);
    RST = 1'b0;
    tick();

    // Directed cases
    run_op(10'd0,    10'd0,    1'b0, 1'b0, 0);
    run_op(10'd1023, 10'd0,    1'b0, 1'b0, 0);
    run_op(10'd0,    10'd1023, 1'b0, 1'b0, 0);
    run_op(10'd100,  10'd5,    1'b1, 1'b0, 0);
    run_op(10'd100,  10'd5,    1'b0, 1'b1, 0);
    run_op(10'd100,  10'd5,    1'b1, 1'b1, 0);
    run_op(10'd0,    10'd0,    1'b0, 1'b0, 5);
    run_op(10'd511,  10'd512,  1'b0, 1'b0, QW + 1);
    run_op(10'd7,    10'd9,    1'b1, 1'b0, 1);
    abort_op(10'd300, 10'd700, 6);
    run_op(10'd300,  10'd700,  1'b0, 1'b0, 0);

    // Random operands, occasional zero operands and ignored competing starts
    for (int i = 0; i < 60; i++) begin
      az = ($urandom_range(0, 7) == 0);
      bz = ($urandom_range(0, 7) == 0);
      if (az || bz) inj = $urandom_range(0, 1);
      else          inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, QW + 1) : 0;
      run_op(FW'($urandom), FW'($urandom), az, bz, inj);
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
